alu_stream_sequencer: RTL and testbench

Byte-stream controller for the shared 32-bit operand/result datapath (arithmetic-shift / add / NAND unit). Collects operand bytes over a valid/ready input stream, fires one operation when the operand register is full, then streams the result bytes out over a valid/ready output stream. It replaces pin-driven byte-select addressing with a self-sequencing handshake, so a host or a neighbouring block can drive the unit without tracking byte indices.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_stream_sequencer_if.sv | 23 ++
 rtl/alu_seq_datapath.sv | 30 +++
 rtl/alu_stream_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_stream_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU byte-stream sequencer.
// Build option: ALU_SEQ_OPCODE_EN enables the opcode byte and the OPC state.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    OPC  = 2'd1,
    EXEC = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int OP_W = 2;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ASR  = 2'd0;
  localparam op_t OP_ADD  = 2'd1;
  localparam op_t OP_NAND = 2'd2;
  localparam op_t OP_XOR  = 2'd3;

endpackage

// File: rtl/alu_stream_sequencer_if.sv
// Operand-in and result-out byte streams of the ALU sequencer, both valid/ready.
// The sequencer is the slave; the host or neighbouring block is the master.
interface alu_stream_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/alu_seq_datapath.sv
// Combinational ALU for the sequencer: arithmetic shift right, add, NAND, XOR.
// Holds no state; the sequencer registers operands and result.
module alu_seq_datapath
  import alu_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  op_t          i_op,
  output logic [W-1:0] o_result
);

  // Only the low five bits of y form the shift amount.
  logic [4:0] w_shamt;
  assign w_shamt = i_y[4:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    o_result = '0;
    case (i_op)
      OP_ASR:  o_result = $unsigned($signed(i_x) >>> w_shamt);
      OP_ADD:  o_result = i_x + i_y;
      OP_NAND: o_result = ~(i_x & i_y);
      OP_XOR:  o_result = i_x ^ i_y;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_stream_sequencer.sv
// Byte-stream sequencer: loads operand bytes, fires one ALU op, streams result bytes out.
// Build option: ALU_SEQ_OPCODE_EN adds an opcode byte after the operand bytes.
module alu_stream_sequencer
  import alu_seq_pkg::*;
#(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   abort,
  alu_stream_sequencer_if.slave  bus,
  output logic                   busy
);

  localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
  localparam int OPND_W    = 8 * BYTES_IN;
  localparam int HALF_W    = OPND_W / 2;
  localparam int W         = 8 << LOG2_BYTES_OUT;

  state_t                    r_state;
  state_t                    w_next;
  logic [LOG2_BYTES_IN-1:0]  r_cnt_in;
  logic [LOG2_BYTES_OUT-1:0] r_cnt_out;
  logic [OPND_W-1:0]         r_opnd;
  logic [W-1:0]              r_result;
  logic [W-1:0]              w_result;
  logic [W-1:0]              w_x;
  logic [W-1:0]              w_y;
  op_t                       w_op;
  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_last_in;
  logic                      w_last_out;

  // A handshake coinciding with abort is discarded.
  assign w_in_fire  = bus.in_valid  && bus.in_ready  && !abort;
  assign w_out_fire = bus.out_valid && bus.out_ready && !abort;
  assign w_last_in  = (r_cnt_in  == '1);
  assign w_last_out = (r_cnt_out == '1);

  assign w_x = W'(r_opnd[HALF_W-1:0]);
  assign w_y = W'(r_opnd[OPND_W-1:HALF_W]);

  alu_seq_datapath #(.W(W)) u_datapath (
    .i_x      (w_x),
    .i_y      (w_y),
    .i_op     (w_op),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire && w_last_in) begin
`ifdef ALU_SEQ_OPCODE_EN
            w_next = OPC;
`else
            w_next = EXEC;
`endif
          end
        end
`ifdef ALU_SEQ_OPCODE_EN
        OPC:     if (w_in_fire) w_next = EXEC;
`endif
        EXEC:    w_next = SEND;
        SEND:    if (w_out_fire && w_last_out) w_next = LOAD;
        default: w_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: operand and result registers are reset too, so out_data reads 0 straight out of reset.
    if (rst) begin
      r_cnt_in  <= '0;
      r_cnt_out <= '0;
      r_opnd    <= '0;
      r_result  <= '0;
    end else if (abort) begin
      r_cnt_in  <= '0;
      r_cnt_out <= '0;
    end else begin
      // The input counter wraps to 0 on the last byte, ready for the next operation.
      if (r_state == LOAD && w_in_fire) begin
        r_opnd[{r_cnt_in, 3'b000} +: 8] <= bus.in_data;
        r_cnt_in                        <= r_cnt_in + 1'b1;
      end
      if (r_state == EXEC) begin
        r_result  <= w_result;
        r_cnt_out <= '0;
      end
      if (r_state == SEND && w_out_fire) begin
        r_cnt_out <= r_cnt_out + 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_OPCODE_EN
  op_t r_op;

  // The opcode persists across operations and is untouched by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_op <= OP_ASR;
    else if (r_state == OPC && w_in_fire) r_op <= bus.in_data[OP_W-1:0];
  end

  assign w_op = r_op;
`else
  assign w_op = OP_ASR;
`endif

  assign bus.in_ready  = (r_state == LOAD) || (r_state == OPC);
  assign bus.out_valid = (r_state == SEND);
  assign bus.out_data  = (r_state == SEND) ? r_result[{r_cnt_out, 3'b000} +: 8] : 8'h00;
  assign bus.out_last  = (r_state == SEND) && w_last_out;
  assign busy          = !((r_state == LOAD) && (r_cnt_in == '0));

endmodule

// File: tb/tb_alu_stream_sequencer.sv
// Directed bench for alu_stream_sequencer: vector table plus abort, backpressure and async-reset sequences.
// Define ALU_SEQ_OPCODE_EN for both bench and RTL to exercise the opcode build.
module tb_alu_stream_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy;

  alu_stream_sequencer_if bus ();

  alu_stream_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] opnd;   // {y, x}
    logic [7:0]  opc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] y, input logic [31:0] x,
                         input logic [7:0] opc, input logic [31:0] exp);
    vec_t v;
    v.name = name;
    v.opnd = {y, x};
    v.opc  = opc;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Present one byte and hold it until the sequencer accepts it; returns at edge + 1.
  task automatic send_byte(input logic [7:0] b);
    int t;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_accept_timeout: in_ready stayed 0 for %0d cycles", t);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Full operation; stall_idx selects the result byte held off for 5 cycles (-1 = none).
  task automatic run_op(input string name, input logic [63:0] opnd, input logic [7:0] opc,
                        input logic [31:0] exp, input int stall_idx);
    for (int i = 0; i < 8; i++) send_byte(opnd[i*8 +: 8]);
`ifdef ALU_SEQ_OPCODE_EN
    send_byte(opc);
`endif
    check({name, " exec_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, " exec_in_ready"},  32'(bus.in_ready),  32'd0);
    @(posedge clk); #1;
    check({name, " latency_out_valid"}, 32'(bus.out_valid), 32'd1);
    for (int j = 0; j < 4; j++) begin
      if (j == stall_idx) begin
        bus.out_ready = 1'b0;
        bus.in_data   = 8'hEE;
        bus.in_valid  = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          check({name, " stall_valid"},    32'(bus.out_valid), 32'd1);
          check({name, " stall_data"},     32'(bus.out_data),  32'(exp[j*8 +: 8]));
          check({name, " stall_last"},     32'(bus.out_last),  32'(j == 3));
          check({name, " stall_in_ready"}, 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, " out_data"},  32'(bus.out_data),  32'(exp[j*8 +: 8]));
      check({name, " out_last"},  32'(bus.out_last),  32'(j == 3));
      @(posedge clk); #1;
    end
    check({name, " done_busy"},      32'(busy),          32'd0);
    check({name, " done_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, " done_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    abort         = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

`ifdef ALU_SEQ_OPCODE_EN
    add_vec("asr_sign_fill", 32'h0000_0004, 32'h8000_0000, 8'h00, 32'hF800_0000);
    add_vec("add_wrap",      32'h0000_0002, 32'hFFFF_FFFF, 8'h01, 32'h0000_0001);
    add_vec("nand_opc_fe",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFE, 32'h0000_0000);
    add_vec("xor",           32'h0FF0_0FF0, 32'hF0F0_F0F0, 8'h03, 32'hFF00_FF00);
    add_vec("nand_mixed",    32'h0000_FFFF, 32'h00FF_00FF, 8'h02, 32'hFFFF_FF00);
    add_vec("asr_mask",      32'h0000_0024, 32'h0000_0100, 8'h00, 32'h0000_0010);
`else
    add_vec("asr_sign_fill", 32'h0000_0004, 32'h8000_0000, 8'h00, 32'hF800_0000);
    add_vec("asr_mask",      32'h0000_0024, 32'h0000_0100, 8'h00, 32'h0000_0010);
    add_vec("asr_zero",      32'h0000_0000, 32'h1234_5678, 8'h00, 32'h1234_5678);
    add_vec("asr_31_pos",    32'h0000_001F, 32'h7FFF_FFFF, 8'h00, 32'h0000_0000);
    add_vec("asr_31_neg",    32'h0000_001F, 32'hFFFF_FFFF, 8'h00, 32'hFFFF_FFFF);
    add_vec("asr_1",         32'h0000_0001, 32'h8000_0001, 8'h00, 32'hC000_0000);
    add_vec("asr_hi_y",      32'hFFFF_FF08, 32'hA5A5_A5A5, 8'h00, 32'hFFA5_A5A5);
`endif

    #12;
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    check("rst out_last",  32'(bus.out_last),  32'd0);
    check("rst busy",      32'(busy),          32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[k]) run_op(vecs[k].name, vecs[k].opnd, vecs[k].opc, vecs[k].exp, -1);

    // Backpressure on the third result byte.
    run_op("stall", {32'h0000_0008, 32'h8765_4321}, 8'h00, 32'hFF87_6543, 2);

    // Abort after 5 operand bytes; the next operation must see only fresh bytes.
    for (int i = 0; i < 5; i++) send_byte(8'hFF);
    check("abort pre_busy", 32'(busy), 32'd1);
    abort        = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check("abort busy",     32'(busy),         32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    run_op("after_abort", {32'h0000_0008, 32'h0000_0100}, 8'h00, 32'h0000_0001, -1);

    // Async reset between edges while mid-SEND.
    for (int i = 0; i < 8; i++) send_byte(8'h55);
`ifdef ALU_SEQ_OPCODE_EN
    send_byte(8'h00);
`endif
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst out_data",  32'(bus.out_data),  32'd0);
    check("async_rst out_last",  32'(bus.out_last),  32'd0);
    check("async_rst in_ready",  32'(bus.in_ready),  32'd1);
    check("async_rst busy",      32'(busy),          32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", {32'h0000_0010, 32'hF000_0000}, 8'h00, 32'hFFFF_F000, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
